// File: rtl/neuromorphic_asic_bridge_pkg.sv
// Shared constants for the neuromorphic ASIC bridge: register offsets,
// field positions/widths, neuron count and the AXI OKAY response code.
package neuromorphic_asic_bridge_pkg;

    // Register offsets (byte addresses)
    localparam logic [8:0] ADDR_DIGIT   = 9'h000;
    localparam logic [8:0] ADDR_NET_OUT = 9'h004;
    localparam logic [8:0] ADDR_PWM_CFG = 9'h008;

    // DIGIT register field
    localparam int unsigned DIGIT_W = 16;

    // PWM_CFG register fields
    localparam int unsigned DUTY_LSB = 0;
    localparam int unsigned WIN_LSB  = 16;
    localparam int unsigned WIN_W    = 16;

    // One window unit is 2**WIN_UNIT_BITS clock cycles
    localparam int unsigned WIN_UNIT_BITS = 8;

    // Neuron spike counters
    localparam int unsigned NUM_NEURONS = 4;
    localparam int unsigned CNT_W       = 8;

    // AXI response
    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/neuromorphic_asic_bridge_spike_counter.sv
// Per-neuron spike counter: 2-flop synchronizer, rising-edge detect and a
// saturating event counter.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   spike_raw    - asynchronous spike level from the ASIC
//   restart      - window boundary: counter restarts, an edge this cycle counts as 1
//   hold         - force the counter to 0 (window halted or reconfigured)
//   count        - live spike count
module neuromorphic_asic_bridge_spike_counter
    import neuromorphic_asic_bridge_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spike_raw,
    input  logic             restart,
    input  logic             hold,
    output logic [CNT_W-1:0] count
);

    logic sync1;
    logic sync2;
    logic sync_d;
    logic edge_c;

    // Synchronizer plus one delay stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            sync1  <= spike_raw;
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    assign edge_c = sync2 & ~sync_d;

    // Saturating counter; an edge on the restart cycle belongs to the new window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (hold) begin
            count <= '0;
        end else if (restart) begin
            count <= CNT_W'(edge_c);
        end else if (edge_c && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/neuromorphic_asic_bridge_top.sv
// AXI4-Lite slave bridging a host CPU to a neuromorphic ASIC: PWM-drives
// 16 pixel inputs and counts spikes of 4 neuron outputs per window.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN - clock and async active-low reset
//   pwm_clk                    - pin-compatibility input, unused
//   digit                      - PWM drive to the ASIC input pixels
//   VAUXP / VAUXN              - neuron output legs (spike = P & ~N)
//   S_AXI_*                    - AXI4-Lite slave (32-bit data)
module neuromorphic_asic_bridge_top
    import neuromorphic_asic_bridge_pkg::*;
#(
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 9,
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned PWM_BITS           = 8
)
(
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic                            pwm_clk,
    output logic [DIGIT_W-1:0]              digit,
    input  logic [NUM_NEURONS-1:0]          VAUXP,
    input  logic [NUM_NEURONS-1:0]          VAUXN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);

    localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
    localparam int unsigned WC_W  = WIN_W + WIN_UNIT_BITS;
    localparam int unsigned NET_W = NUM_NEURONS * CNT_W;

    localparam logic [1:0] SEL_DIGIT   = ADDR_DIGIT[3:2];
    localparam logic [1:0] SEL_NET_OUT = ADDR_NET_OUT[3:2];
    localparam logic [1:0] SEL_PWM_CFG = ADDR_PWM_CFG[3:2];

    wire clk   = S_AXI_ACLK;
    wire rst_n = S_AXI_ARESETN;

    // Register state
    logic [DIGIT_W-1:0]  digit_mask;
    logic [PWM_BITS-1:0] duty;
    logic [WIN_W-1:0]    win;
    logic [NET_W-1:0]    net_out;
    logic [NET_W-1:0]    live_cnt;

    // AXI channel state
    logic          awready_q;
    logic          bvalid_q;
    logic          arready_q;
    logic          rvalid_q;
    logic [DW-1:0] rdata_q;

    // PWM / window state
    logic [PWM_BITS-1:0] pc;
    logic [DIGIT_W-1:0]  digit_q;
    logic [WC_W-1:0]     wc;

    logic                   aw_mapped_c;
    logic                   ar_mapped_c;
    logic                   cfg_wr_c;
    logic                   win_active_c;
    logic                   term_c;
    logic [WC_W-1:0]        wc_last_c;
    logic [DW-1:0]          rd_mux_c;
    logic [NUM_NEURONS-1:0] spike_raw_c;

    // Byte-lane bits of the addresses, WSTRB and pwm_clk carry no information here
    logic unused_ok;
    assign unused_ok = &{1'b0, pwm_clk, S_AXI_WSTRB, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign aw_mapped_c = (S_AXI_AWADDR[AW-1:4] == '0);
    assign ar_mapped_c = (S_AXI_ARADDR[AW-1:4] == '0);

    // Write channel: ready pulses one cycle after both valids, commit on that cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            awready_q <= S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q && !awready_q;
            if (awready_q) begin
                bvalid_q <= 1'b1;
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    assign cfg_wr_c = awready_q && aw_mapped_c && (S_AXI_AWADDR[3:2] == SEL_PWM_CFG);

    // Writable registers; full-word writes, NET_OUT and unmapped ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_mask <= '0;
            duty       <= '0;
            win        <= '0;
        end else if (awready_q && aw_mapped_c) begin
            if (S_AXI_AWADDR[3:2] == SEL_DIGIT) begin
                digit_mask <= S_AXI_WDATA[DIGIT_W-1:0];
            end
            if (S_AXI_AWADDR[3:2] == SEL_PWM_CFG) begin
                duty <= S_AXI_WDATA[DUTY_LSB +: PWM_BITS];
                win  <= S_AXI_WDATA[WIN_LSB +: WIN_W];
            end
        end
    end

    // Read data mux
    always_comb begin
        rd_mux_c = '0;
        if (ar_mapped_c) begin
            case (S_AXI_ARADDR[3:2])
                SEL_DIGIT:   rd_mux_c = DW'(digit_mask);
                SEL_NET_OUT: rd_mux_c = DW'(net_out);
                SEL_PWM_CFG: rd_mux_c = DW'(duty) | (DW'(win) << WIN_LSB);
                default:     rd_mux_c = '0;
            endcase
        end
    end

    // Read channel: ARREADY pulse captures data, RVALID holds until RREADY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            arready_q <= S_AXI_ARVALID && !rvalid_q && !arready_q;
            if (arready_q) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux_c;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;

    // Free-running PWM counter and registered pixel drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= '0;
            digit_q <= '0;
        end else begin
            pc      <= pc + PWM_BITS'(1);
            digit_q <= digit_mask & {DIGIT_W{pc < duty}};
        end
    end

    assign digit = digit_q;

    // Window timer: terminal count is WIN*256-1
    assign win_active_c = (win != '0);
    assign wc_last_c    = {win - WIN_W'(1), {WIN_UNIT_BITS{1'b1}}};
    assign term_c       = win_active_c && (wc == wc_last_c) && !cfg_wr_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wc      <= '0;
            net_out <= '0;
        end else begin
            if (cfg_wr_c || !win_active_c || term_c) begin
                wc <= '0;
            end else begin
                wc <= wc + WC_W'(1);
            end
            if (term_c) begin
                net_out <= live_cnt;
            end
        end
    end

    assign spike_raw_c = VAUXP & ~VAUXN;

    // One counter per neuron lane
    for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_neuron
        neuromorphic_asic_bridge_spike_counter u_spike_counter (
            .clk       (clk),
            .rst_n     (rst_n),
            .spike_raw (spike_raw_c[i]),
            .restart   (term_c),
            .hold      (cfg_wr_c || !win_active_c),
            .count     (live_cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_neuromorphic_asic_bridge_top.sv
// Directed self-checking bench for neuromorphic_asic_bridge_top.
module tb_neuromorphic_asic_bridge_top;

    logic        S_AXI_ACLK;
    logic        S_AXI_ARESETN;
    logic        pwm_clk;
    logic [15:0] digit;
    logic [3:0]  VAUXP;
    logic [3:0]  VAUXN;
    logic [8:0]  S_AXI_AWADDR;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [8:0]  S_AXI_ARADDR;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] data;
        string       tag;
    } exp_t;

    exp_t sb[$];

    neuromorphic_asic_bridge_top dut (
        .S_AXI_ACLK    (S_AXI_ACLK),
        .S_AXI_ARESETN (S_AXI_ARESETN),
        .pwm_clk       (pwm_clk),
        .digit         (digit),
        .VAUXP         (VAUXP),
        .VAUXN         (VAUXN),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY)
    );

    initial S_AXI_ACLK = 1'b0;
    always #5 S_AXI_ACLK = ~S_AXI_ACLK;
    assign pwm_clk = S_AXI_ACLK;

    always @(posedge S_AXI_ACLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge S_AXI_ACLK);
    endtask

    task automatic axi_write(input logic [8:0] addr, input logic [31:0] data);
        int n = 0;
        @(negedge S_AXI_ACLK);
        S_AXI_AWADDR  = addr;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = 4'h0;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_BREADY  = 1'b1;
        while (!S_AXI_AWREADY && n < 20) begin
            @(negedge S_AXI_ACLK);
            n++;
        end
        check("wr_awready", 32'(S_AXI_AWREADY), 32'd1);
        check("wr_wready", 32'(S_AXI_WREADY), 32'd1);
        @(negedge S_AXI_ACLK);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check("wr_awready_pulse", 32'(S_AXI_AWREADY), 32'd0);
        check("wr_bvalid", 32'(S_AXI_BVALID), 32'd1);
        check("wr_bresp", 32'(S_AXI_BRESP), 32'd0);
        @(negedge S_AXI_ACLK);
        check("wr_bvalid_clr", 32'(S_AXI_BVALID), 32'd0);
    endtask

    task automatic axi_read(input logic [8:0] addr, input logic [31:0] exp, input string tag,
                            input int hold);
        int   n = 0;
        exp_t e;
        @(negedge S_AXI_ACLK);
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b0;
        sb.push_back('{data: exp, tag: tag});
        while (!S_AXI_ARREADY && n < 20) begin
            @(negedge S_AXI_ACLK);
            n++;
        end
        check({tag, "_arready"}, 32'(S_AXI_ARREADY), 32'd1);
        @(negedge S_AXI_ACLK);
        S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!S_AXI_RVALID && n < 20) begin
            @(negedge S_AXI_ACLK);
            n++;
        end
        check({tag, "_rvalid"}, 32'(S_AXI_RVALID), 32'd1);
        e = sb.pop_front();
        check(e.tag, S_AXI_RDATA, e.data);
        check({tag, "_rresp"}, 32'(S_AXI_RRESP), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge S_AXI_ACLK);
            check({tag, "_rvalid_hold"}, 32'(S_AXI_RVALID), 32'd1);
            check({tag, "_rdata_hold"}, S_AXI_RDATA, e.data);
        end
        S_AXI_RREADY = 1'b1;
        @(negedge S_AXI_ACLK);
        check({tag, "_rvalid_clr"}, 32'(S_AXI_RVALID), 32'd0);
        S_AXI_RREADY = 1'b0;
    endtask

    // Count cycles with digit[0] high over one PWM period, and any activity on digit[15:1]
    task automatic pwm_measure(input int exp_hi, input string tag);
        int   hi    = 0;
        logic upper = 1'b0;
        for (int i = 0; i < 256; i++) begin
            @(negedge S_AXI_ACLK);
            if (digit[0]) hi++;
            upper = upper | (|digit[15:1]);
        end
        check({tag, "_hi"}, 32'(hi), 32'(exp_hi));
        check({tag, "_upper"}, 32'(upper), 32'd0);
    endtask

    task automatic pulse(input logic [3:0] mask, input int hi, input int lo);
        VAUXP = VAUXP | mask;
        repeat (hi) @(negedge S_AXI_ACLK);
        VAUXP = VAUXP & ~mask;
        repeat (lo) @(negedge S_AXI_ACLK);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start;

        S_AXI_ARESETN = 1'b0;
        VAUXP         = '0;
        VAUXN         = '0;
        S_AXI_AWADDR  = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = '0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        S_AXI_ARADDR  = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;

        // Reset state
        repeat (3) @(negedge S_AXI_ACLK);
        check("rst_digit", 32'(digit), 32'd0);
        check("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
        check("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
        check("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
        check("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
        S_AXI_ARESETN = 1'b1;
        axi_read(9'h000, 32'h0000_0000, "rst_rd_digit", 0);
        axi_read(9'h004, 32'h0000_0000, "rst_rd_netout", 0);
        axi_read(9'h008, 32'h0000_0000, "rst_rd_cfg", 0);

        // Full-word writes with WSTRB=0, field masking on readback
        axi_write(9'h000, 32'hDEAD_BEEF);
        axi_write(9'h004, 32'hDEAD_BEEF);
        axi_write(9'h008, 32'hDEAD_BEEF);
        axi_read(9'h000, 32'h0000_BEEF, "rb_digit", 0);
        axi_read(9'h004, 32'h0000_0000, "rb_netout", 0);
        axi_read(9'h008, 32'hDEAD_00EF, "rb_cfg", 0);

        // PWM duty sweep on pixel 0 (WIN=0)
        axi_write(9'h000, 32'h0000_0001);
        axi_write(9'h008, 32'h0000_0040);
        pwm_measure(64, "pwm_duty40");
        axi_write(9'h008, 32'h0000_0000);
        pwm_measure(0, "pwm_duty0");
        axi_write(9'h008, 32'h0000_00FF);
        pwm_measure(255, "pwm_duty255");

        // Unmapped and reserved addresses ignore writes and read 0
        axi_write(9'h100, 32'hFFFF_FFFF);
        axi_write(9'h00C, 32'hFFFF_FFFF);
        axi_read(9'h100, 32'h0000_0000, "rd_unmapped", 0);
        axi_read(9'h00C, 32'h0000_0000, "rd_reserved", 0);
        axi_read(9'h008, 32'h0000_00FF, "rd_cfg_after_unmapped", 0);

        // Read data held stable while RREADY stays low
        axi_read(9'h000, 32'h0000_0001, "rd_hold", 10);

        // WIN=1: 5 edges per window on lane 2; lane 1 toggles but VAUXN[1] masks it
        axi_write(9'h000, 32'h0000_0000);
        axi_write(9'h008, 32'h0001_0000);
        VAUXN = 4'b0010;
        for (int w = 0; w < 4; w++) begin
            start = cyc;
            wait_until(start + 40);
            for (int k = 0; k < 5; k++) pulse(4'b0110, 4, 20);
            axi_read(9'h004, (w == 0) ? 32'h0000_0000 : 32'h0005_0000, "win_netout", 0);
            wait_until(start + 256);
        end
        VAUXN = 4'b0000;

        // WIN=4: 300 edges on lane 0 saturate at 255
        axi_write(9'h008, 32'h0004_0000);
        start = cyc;
        for (int k = 0; k < 300; k++) pulse(4'b0001, 1, 1);
        wait_until(start + 1040);
        axi_read(9'h004, 32'h0000_00FF, "sat_netout", 0);

        // WIN=0 halts the window; NET_OUT keeps its value
        axi_write(9'h008, 32'h0000_0000);
        start = cyc;
        for (int k = 0; k < 20; k++) pulse(4'b0001, 2, 2);
        wait_until(start + 300);
        axi_read(9'h004, 32'h0000_00FF, "halt_netout", 0);

        // Reset in the middle of a write: no response, registers cleared
        axi_write(9'h008, 32'h0000_00FF);
        axi_write(9'h000, 32'h0000_FFFF);
        @(negedge S_AXI_ACLK);
        S_AXI_AWADDR  = 9'h000;
        S_AXI_WDATA   = 32'h0000_1234;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_BREADY  = 1'b0;
        @(negedge S_AXI_ACLK);
        check("midrst_awready", 32'(S_AXI_AWREADY), 32'd1);
        S_AXI_ARESETN = 1'b0;
        #1;
        check("midrst_bvalid", 32'(S_AXI_BVALID), 32'd0);
        check("midrst_awready_clr", 32'(S_AXI_AWREADY), 32'd0);
        check("midrst_digit", 32'(digit), 32'd0);
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        repeat (2) @(negedge S_AXI_ACLK);
        S_AXI_ARESETN = 1'b1;
        repeat (2) @(negedge S_AXI_ACLK);
        check("postrst_bvalid", 32'(S_AXI_BVALID), 32'd0);
        axi_read(9'h000, 32'h0000_0000, "postrst_digit", 0);
        axi_read(9'h004, 32'h0000_0000, "postrst_netout", 0);
        axi_read(9'h008, 32'h0000_0000, "postrst_cfg", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/neuromorphic_asic_bridge_top.md
Name: neuromorphic_asic_bridge_top

Overview:
- AXI4-Lite slave bridging a host CPU to an external neuromorphic ASIC.
- Drives 16 PWM-encoded input lines (a 4x4 "digit" pixel image) into the ASIC.
- Samples 4 ASIC neuron output lines and counts spikes per neuron over a programmable window.
- Exposes the latched spike counts to software through a read-only register.

Parameters:
- C_S_AXI_ADDR_WIDTH, 9, AXI address width.
- C_S_AXI_DATA_WIDTH, 32, AXI data width (only 32 is supported).
- PWM_BITS, 8, PWM counter and duty width.

Ports:
- S_AXI_ACLK  in  1  sole clock for all logic.
- S_AXI_ARESETN  in  1  asynchronous, active-low reset.
- pwm_clk  in  1  pin-compatibility input only; not used internally; board ties it to the S_AXI_ACLK source.
- digit  out  16  PWM drive to ASIC input pixels.
- VAUXP  in  4  neuron output, positive leg.
- VAUXN  in  4  neuron output, negative leg.
- S_AXI_AWADDR  in  9 / S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1.
- S_AXI_WDATA  in  32 / S_AXI_WSTRB in 4 / S_AXI_WVALID in 1 / S_AXI_WREADY out 1.
- S_AXI_BRESP  out  2 / S_AXI_BVALID out 1 / S_AXI_BREADY in 1.
- S_AXI_ARADDR  in  9 / S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1.
- S_AXI_RDATA  out  32 / S_AXI_RRESP out 2 / S_AXI_RVALID out 1 / S_AXI_RREADY in 1.

Behaviour:
- Reset (async assert, sync release): all registers, counters, AXI outputs and digit go to 0.
- Register map, decoded on addr[3:2]; addr[8:4]!=0 is unmapped:
  - 0x000 DIGIT, RW: bits [15:0] are the pixel enable mask; bits [31:16] read 0.
  - 0x004 NET_OUT, RO: bits [31:0] = {cnt3, cnt2, cnt1, cnt0}, 8 bits each, from the last completed window. Writes ignored.
  - 0x008 PWM_CFG, RW: bits [7:0] = duty; bits [15:8] read 0; bits [31:16] = WIN (window length in units of 256 cycles).
  - 0x00C and unmapped addresses: read 0, writes ignored.
- WSTRB is ignored; every accepted write is a full 32-bit write.
- Write channel:
  - When AWVALID && WVALID && !BVALID, pulse AWREADY and WREADY high for one cycle and commit the write that cycle.
  - BVALID rises the next cycle and holds until BREADY.
  - BRESP is always 00.
- Read channel:
  - When ARVALID && !RVALID, pulse ARREADY for one cycle and register RDATA.
  - RVALID rises the next cycle and holds, with RDATA stable, until RREADY.
  - RRESP is always 00.
  - Read and write channels are independent and may complete in the same cycle.
- PWM:
  - 8-bit free-running counter pc, wrapping 255 to 0.
  - digit[i] = DIGIT[i] & (pc < duty), registered.
  - duty 0 keeps digit low; duty 255 gives high for 255 of every 256 cycles.
- Neuron input: spike_i = VAUXP[i] & ~VAUXN[i], passed through a 2-flop synchronizer. A count event is a rising edge of the synchronized signal.
- Window:
  - Cycle counter wc counts to WIN*256-1. At terminal count, NET_OUT latches the live counters and the live counters clear in the same cycle.
  - An edge arriving on the terminal cycle counts into the new window.
  - Live counters saturate at 255.
  - WIN=0: window halted, live counters held at 0, NET_OUT holds its value.
  - A write to PWM_CFG restarts wc and clears the live counters.
- Reset mid-transaction aborts it; no response is issued after reset.

Decomposition:
- Shared package holds the register offsets (DIGIT=0x000, NET_OUT=0x004, PWM_CFG=0x008), the field LSB/width constants, and the OKAY response code.
- One natural sub-module, spike_counter: one instance per neuron, containing synchronizer, edge detect and saturating counter.
- AXI slave logic, PWM and window timer live in the top.

Test Plan:
- Reset, then read 0x000, 0x004 and 0x008 -> all return 0x00000000; digit=0; RRESP=00.
- Write 0xDEADBEEF with WSTRB=0 to 0x000, 0x004 and 0x008 (BREADY=1) -> each write gets one-cycle AWREADY/WREADY and then BVALID with BRESP=00. Readback: 0x000=0x0000BEEF, 0x004 unchanged, 0x008=0xDEAD00EF.
- DIGIT=0x0001, duty=0x40 -> digit[0] high 64 of every 256 cycles, digit[15:1]=0; duty=0 -> digit constantly 0.
- WIN=1; drive VAUXP[2]=1/VAUXN[2]=0 toggling 5 times per 256 cycles -> NET_OUT reads 0x00050000 after each window; other lanes 0.
- Hold neuron 0 toggling more than 255 times in one window -> cnt0 reads 0xFF (saturation).
- Hold RREADY low for 10 cycles after ARREADY -> RVALID and RDATA stay stable; assert ARESETN low mid-write -> BVALID=0 and registers=0.
